// File: rtl/nq_pkg.sv
// Shared definitions for the nqcpu front end: fetch FSM states and default PC increment.
package nq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam int unsigned NQ_PC_STEP = 2;

endpackage

// File: rtl/nq_prefetch_if.sv
// Memory-bus and decode-side signals of the prefetch unit, grouped for port binding.
interface nq_prefetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) ();
  localparam int LVL_W = $clog2(DEPTH + 1);

  // Handshakes: a memory beat is a cycle with mem_re_o=1 and mem_wait_i=0;
  // mem_addr_o and mem_re_o hold while mem_wait_i=1. Decode takes the head
  // when instr_valid_o & instr_ready_i on a rising edge; valid never depends on ready.
  logic              mem_grant_i;
  logic              mem_wait_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_re_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              instr_valid_o;
  logic [DATA_W-1:0] instr_o;
  logic [ADDR_W-1:0] instr_pc_o;
  logic              instr_ready_i;
  logic [LVL_W-1:0]  level_o;

  modport master (
    input  mem_grant_i, mem_wait_i, mem_data_i, redirect_i, redirect_pc_i, instr_ready_i,
    output mem_addr_o, mem_re_o, instr_valid_o, instr_o, instr_pc_o, level_o
  );

  modport slave (
    output mem_grant_i, mem_wait_i, mem_data_i, redirect_i, redirect_pc_i, instr_ready_i,
    input  mem_addr_o, mem_re_o, instr_valid_o, instr_o, instr_pc_o, level_o
  );

endinterface

// File: rtl/nq_sync_fifo.sv
// Synchronous FIFO with occupancy count and single-cycle flush; DEPTH must be a power of two.
module nq_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/nq_prefetch.sv
// Instruction prefetch unit: sequential bus reads into a PC-tagged queue, with redirect and in-flight discard.
module nq_prefetch
  import nq_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 16,
  parameter int              DEPTH    = 4,
  parameter int unsigned     PC_STEP  = NQ_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  nq_prefetch_if.master bus,
  output fetch_state_e  dbg_state
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_pc, req_addr, push_pc;
  logic [LVL_W-1:0]  level;
  logic              full, empty;
  logic              re_int, push, pop;
  logic [DATA_W+ADDR_W-1:0] rdata;

  always_comb begin
    re_int  = 1'b0;
    bus.mem_addr_o = fetch_pc;
    push_pc = fetch_pc;
    push    = 1'b0;
    case (state)
      ST_FETCH: begin
        re_int = bus.mem_grant_i & ~full & ~bus.redirect_i;
        push   = re_int & ~bus.mem_wait_i;
      end
      ST_WAIT: begin
        re_int         = 1'b1;
        bus.mem_addr_o = req_addr;
        push_pc        = req_addr;
        push           = ~bus.mem_wait_i & ~bus.redirect_i;
      end
      ST_DISCARD: begin
        re_int         = 1'b1;
        bus.mem_addr_o = req_addr;
      end
      default: ;
    endcase
  end

  // Gating with rst_n drops the request the moment reset asserts, even mid-read.
  assign bus.mem_re_o = rst_n & re_int;
  assign pop          = ~empty & bus.instr_ready_i & ~bus.redirect_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        ST_FETCH: begin
          if (re_int) begin
            req_addr <= fetch_pc;
            if (bus.mem_wait_i) state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A redirect while still waiting must let the stale beat complete unseen.
          if (bus.redirect_i)       state <= bus.mem_wait_i ? ST_DISCARD : ST_FETCH;
          else if (!bus.mem_wait_i) state <= ST_FETCH;
        end
        ST_DISCARD: begin
          if (!bus.mem_wait_i) state <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
      if (bus.redirect_i)  fetch_pc <= bus.redirect_pc_i;
      else if (push)       fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
    end
  end

  nq_sync_fifo #(
    .W     (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.redirect_i),
    .push  (push),
    .wdata ({bus.mem_data_i, push_pc}),
    .pop   (pop),
    .rdata (rdata),
    .count (level),
    .full  (full),
    .empty (empty)
  );

  assign bus.instr_valid_o = ~empty;
  assign bus.instr_o       = rdata[ADDR_W +: DATA_W];
  assign bus.instr_pc_o    = rdata[ADDR_W-1:0];
  assign bus.level_o       = level;
  assign dbg_state         = state;

endmodule

// File: tb/tb_nq_prefetch.sv
// Directed bench for nq_prefetch: fill, stream, wait states, discard, wrap, grant gaps, async reset.
module tb_nq_prefetch;
  import nq_pkg::*;

  localparam logic [15:0] KEY = 16'hA5A5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  fetch_state_e dbg_state;
  int           n_assert = 0;
  int           n_fail   = 0;

  nq_prefetch_if #(.ADDR_W(16), .DATA_W(16), .DEPTH(4)) bus ();

  nq_prefetch #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .PC_STEP(2), .RESET_PC(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Memory model: every word is its address xor a key.
  assign bus.mem_data_i = bus.mem_addr_o ^ KEY;

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [15:0] pc);
    chk({tag, "_valid"}, 32'(bus.instr_valid_o), 32'd1);
    chk({tag, "_pc"},    32'(bus.instr_pc_o),    32'(pc));
    chk({tag, "_instr"}, 32'(bus.instr_o),       32'(pc ^ KEY));
  endtask

  task automatic chk_bus(input string tag, input logic re, input logic [15:0] addr);
    chk({tag, "_re"}, 32'(bus.mem_re_o), 32'(re));
    if (re) chk({tag, "_addr"}, 32'(bus.mem_addr_o), 32'(addr));
  endtask

  initial begin
    bus.mem_grant_i   = 1'b1;
    bus.mem_wait_i    = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 16'h0000;
    bus.instr_ready_i = 1'b0;

    // Reset state
    tick(); #1;
    chk("rst_re", 32'(bus.mem_re_o), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("rst_level", 32'(bus.level_o), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr_o), 32'h0000);
    chk("rst_state", 32'(dbg_state), 32'(ST_FETCH));

    // Fill with decode stalled: 0,2,4,6 on consecutive cycles, then blocked at full
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk_bus($sformatf("fill%0d", i), 1'b1, 16'(2 * i));
      chk($sformatf("fill%0d_level", i), 32'(bus.level_o), 32'(i));
      tick(); #1;
    end
    chk("full_level", 32'(bus.level_o), 32'd4);
    chk("full_re", 32'(bus.mem_re_o), 32'd0);
    chk_head("full_head", 16'h0000);

    // Redirect with full queue and a simultaneous pop
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 16'h0040;
    bus.instr_ready_i = 1'b1;
    #1;
    chk("redir_full_re", 32'(bus.mem_re_o), 32'd0);
    tick();
    bus.redirect_i = 1'b0;
    #1;
    chk("redir_full_level", 32'(bus.level_o), 32'd0);
    chk("redir_full_valid", 32'(bus.instr_valid_o), 32'd0);
    chk_bus("redir_full_issue", 1'b1, 16'h0040);
    tick(); #1;

    // Steady stream, one word per cycle at level 1
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("stream%0d", i), 16'(16'h0040 + 2 * i));
      chk($sformatf("stream%0d_level", i), 32'(bus.level_o), 32'd1);
      chk_bus($sformatf("stream%0d", i), 1'b1, 16'(16'h0042 + 2 * i));
      tick(); #1;
    end
    chk_head("stream_end", 16'h0048);

    // Three wait cycles on the read at 004A: held for four cycles, one push
    bus.mem_wait_i = 1'b1;
    #1;
    chk_bus("wait0", 1'b1, 16'h004A);
    for (int i = 1; i < 3; i++) begin
      tick(); #1;
      chk_bus($sformatf("wait%0d", i), 1'b1, 16'h004A);
      chk($sformatf("wait%0d_state", i), 32'(dbg_state), 32'(ST_WAIT));
      chk($sformatf("wait%0d_valid", i), 32'(bus.instr_valid_o), 32'd0);
    end
    tick();
    bus.mem_wait_i = 1'b0;
    #1;
    chk_bus("wait3", 1'b1, 16'h004A);
    tick(); #1;
    chk_head("wait_push", 16'h004A);
    chk("wait_push_level", 32'(bus.level_o), 32'd1);
    chk_bus("wait_next", 1'b1, 16'h004C);
    tick(); #1;
    chk_head("wait_after", 16'h004C);

    // Redirect while waiting on 004E; beat completes two cycles later in DISCARD
    bus.mem_wait_i = 1'b1;
    tick();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 16'h0100;
    #1;
    chk_bus("disc_redir", 1'b1, 16'h004E);
    tick();
    bus.redirect_i = 1'b0;
    #1;
    chk("disc_state", 32'(dbg_state), 32'(ST_DISCARD));
    chk_bus("disc_hold", 1'b1, 16'h004E);
    chk("disc_level", 32'(bus.level_o), 32'd0);
    tick();
    bus.mem_wait_i = 1'b0;
    #1;
    chk_bus("disc_done", 1'b1, 16'h004E);
    tick(); #1;
    chk("disc_exit_state", 32'(dbg_state), 32'(ST_FETCH));
    chk("disc_exit_valid", 32'(bus.instr_valid_o), 32'd0);
    chk_bus("disc_new", 1'b1, 16'h0100);
    tick(); #1;
    chk_head("disc_first", 16'h0100);

    // PC wrap FFFC, FFFE, 0000, then two cycles without grant
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 16'hFFFC;
    #1;
    chk("wrap_redir_re", 32'(bus.mem_re_o), 32'd0);
    tick();
    bus.redirect_i = 1'b0;
    #1;
    chk("wrap_level", 32'(bus.level_o), 32'd0);
    chk_bus("wrap_i0", 1'b1, 16'hFFFC);
    tick(); #1;
    chk_head("wrap_h0", 16'hFFFC);
    chk_bus("wrap_i1", 1'b1, 16'hFFFE);
    tick(); #1;
    chk_head("wrap_h1", 16'hFFFE);
    chk_bus("wrap_i2", 1'b1, 16'h0000);
    tick();
    bus.mem_grant_i = 1'b0;
    #1;
    chk_head("wrap_h2", 16'h0000);
    chk("nogrant0_re", 32'(bus.mem_re_o), 32'd0);
    tick(); #1;
    chk("nogrant1_re", 32'(bus.mem_re_o), 32'd0);
    chk("nogrant1_valid", 32'(bus.instr_valid_o), 32'd0);
    tick();
    bus.mem_grant_i = 1'b1;
    #1;
    chk_bus("regrant", 1'b1, 16'h0002);
    tick(); #1;
    chk_head("regrant_h", 16'h0002);

    // Async reset in the middle of a wait aborts the read at once
    bus.mem_wait_i = 1'b1;
    tick(); #1;
    chk("arst_pre_state", 32'(dbg_state), 32'(ST_WAIT));
    chk_bus("arst_pre", 1'b1, 16'h0004);
    rst_n = 1'b0;
    #1;
    chk("arst_re", 32'(bus.mem_re_o), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(ST_FETCH));
    chk("arst_addr", 32'(bus.mem_addr_o), 32'h0000);
    chk("arst_valid", 32'(bus.instr_valid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
